data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Word-organised data memory that serves the processor datapath's load/store traffic.
- Sits between the datapath's memory-side signals (aluout as address, writedata, readdata) and the on-chip RAM array.
- Adds a valid/ready request handshake, configurable wait states, and alignment/range error reporting, so later multi-cycle cores can stall on memory.

Parameters:
- DEPTH, 64, number of 32-bit words; valid word index is 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states inserted between accept and response; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_ready  output  1  block can accept a request this cycle.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data; qualified by resp_valid.
- resp_err  output  1  request was misaligned or out of range; qualified by resp_valid.
- busy  output  1  a request is in flight (state is not IDLE).
- err_count  output  8  saturating count of errored requests.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, err_count=0.
  - Latched request registers are cleared.
  - RAM contents are not cleared by reset; they are undefined after power-up and unchanged by later resets.
- State machine (IDLE, WAIT, RESP):
  - IDLE:
    - req_ready=1.
    - Accept happens on a rising edge where req_valid=1. Latch req_we, req_addr, req_wdata.
    - Compute err = (req_addr[1:0]!=0) or (req_addr[31:2] >= DEPTH).
    - If WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with cnt=WAIT_CYCLES-1.
    - With req_valid=0, stay in IDLE.
  - WAIT:
    - req_ready=0 and busy=1.
    - If cnt=0, go to RESP; otherwise decrement cnt.
    - Request inputs are ignored.
  - RESP:
    - resp_valid=1 for exactly one cycle; req_ready=0, busy=1.
    - Always return to IDLE on the next edge. No back-to-back accept from RESP.
- Latency and throughput:
  - Accept at edge E0 gives resp_valid high in the cycle after edge E0+WAIT_CYCLES.
  - Throughput is one request per WAIT_CYCLES+2 cycles.
- Response data:
  - Load, no error: resp_rdata = mem[addr[31:2]], reflecting every store committed before this request was accepted.
  - Store or error: resp_rdata = 0.
  - resp_err = latched err.
  - resp_rdata and resp_err are registered. They hold their last value outside RESP and are meaningful only while resp_valid=1.
- Store commit:
  - A store commits to RAM on the edge that exits RESP, and only if err=0.
  - An errored store never modifies RAM.
- err_count:
  - Increments on the edge exiting RESP when err=1.
  - Saturates at 255 and never wraps.
- Reset mid-operation:
  - Reset asserted in WAIT or RESP aborts the request.
  - The pending store is dropped and no resp_valid is produced.
  - The RAM word is unchanged.
- Address bits above the index range count only through the range check; there is no aliasing.
- req_valid held high across a response: the block re-accepts in the following IDLE cycle. Requesters must deassert req_valid after accept if they do not want a repeat.

Test Plan:
- Store 0xDEADBEEF to 0x10, then load 0x10, WAIT_CYCLES=2 → each resp_valid comes 3 edges after accept. Load gives resp_rdata=0xDEADBEEF, resp_err=0.
- Load from 0x13 (misaligned) and store to 0x100 with DEPTH=64 (out of range) → both give resp_err=1 and resp_rdata=0, err_count=2. Word 0 is unchanged when read back.
- Hold req_valid=1 continuously → req_ready pattern is 1,0,0,0 repeating and resp_valid pulses every 4 cycles. Exactly one accept happens per IDLE cycle.
- WAIT_CYCLES=0 build: accept at E0 → resp_valid in the cycle after E0. Back-to-back loads of 0x0 and 0x4 return correct distinct data.
- Store 0x12345678 to 0x8, assert reset during WAIT → resp_valid never asserts, outputs return to reset values, and a later load of 0x8 returns the old value.
- Issue 300 misaligned requests → err_count rises to 255 and stays at 255; no other outputs are disturbed.

Source files
------------

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word data memory with valid/ready request, wait states and error reporting
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [7:0]  err_count
);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    logic [31:0]     mem_q [DEPTH];
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rerr_q, rerr_d;
    logic [7:0]      errcnt_q, errcnt_d;

    logic            req_err;
    logic [IDXW-1:0] req_idx;
    logic            src_we, src_err, load_resp;
    logic [IDXW-1:0] src_idx;

    // Upper address bits only feed the range check, so out-of-range never aliases.
    assign req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
    assign req_idx = req_addr[IDXW+1:2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        errcnt_d  = errcnt_q;
        src_we    = we_q;
        src_err   = err_q;
        src_idx   = idx_q;
        load_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    src_we  = req_we;
                    src_err = req_err;
                    src_idx = req_idx;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_RESP;
                    load_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (err_q && (errcnt_q != 8'hFF)) begin
                    errcnt_d = errcnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Response registers load on the edge entering RESP and hold afterwards.
        if (load_resp) begin
            rerr_d  = src_err;
            rdata_d = (!src_we && !src_err) ? mem_q[src_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rerr_q   <= 1'b0;
            errcnt_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            errcnt_q <= errcnt_d;
        end
    end

    // RAM is never reset; an abort forces state to IDLE so the pending store is lost.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && !err_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = rerr_q;
    assign err_count  = errcnt_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder (WAIT_CYCLES=2 and 0 builds)
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_we, a_ready, a_rvalid, a_rerr, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [7:0]  a_ecnt;
    logic        b_valid, b_we, b_ready, b_rvalid, b_rerr, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [7:0]  b_ecnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          ecnt_model = 0;
    logic [32:0] sb_q[$];
    logic [31:0] m_a [64];
    logic [31:0] m_b [64];
    logic [32:0] item;
    int          seen;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_ready(a_ready), .resp_valid(a_rvalid), .resp_rdata(a_rdata),
        .resp_err(a_rerr), .busy(a_busy), .err_count(a_ecnt)
    );

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_ready(b_ready), .resp_valid(b_rvalid), .resp_rdata(b_rdata),
        .resp_err(b_rerr), .busy(b_busy), .err_count(b_ecnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
    endfunction

    task automatic drive(input int sel, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            a_valid = v; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            b_valid = v; b_we = we; b_addr = addr; b_wdata = wd;
        end
    endtask

    task automatic do_req(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        int          k;
        bit          got;
        logic        e;
        logic [5:0]  idx;
        logic [31:0] d;
        logic [32:0] it;
        k = 0;
        while (!(sel == 0 ? a_ready : b_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        e   = exp_err(addr);
        idx = addr[7:2];
        d   = 32'd0;
        if (!we && !e) d = (sel == 0) ? m_a[idx] : m_b[idx];
        if (we && !e) begin
            if (sel == 0) m_a[idx] = wd;
            else          m_b[idx] = wd;
        end
        sb_q.push_back({e, d});
        drive(sel, 1'b1, we, addr, wd);
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        got = 0;
        k   = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clk);
            if (sel == 0 ? a_rvalid : b_rvalid) begin
                got = 1;
                k   = c;
            end
        end
        chk("latency", 32'(k), (sel == 0) ? 32'd3 : 32'd1);
        it = sb_q.pop_front();
        if (got) begin
            chk("resp_rdata", (sel == 0) ? a_rdata : b_rdata, it[31:0]);
            chk("resp_err", {31'b0, (sel == 0) ? a_rerr : b_rerr}, {31'b0, it[32]});
        end
        if (sel == 0) begin
            @(negedge clk);
            if (e && ecnt_model < 255) ecnt_model++;
            chk("err_count", {24'b0, a_ecnt}, 32'(ecnt_model));
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rst_ready", {31'b0, a_ready}, 32'd1);
        chk("rst_valid", {31'b0, a_rvalid}, 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_err", {31'b0, a_rerr}, 32'd0);
        chk("rst_busy", {31'b0, a_busy}, 32'd0);
        chk("rst_ecnt", {24'b0, a_ecnt}, 32'd0);
        chk("rst_ready0", {31'b0, b_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
        do_req(0, 1'b0, 32'h10, 32'd0);

        do_req(0, 1'b1, 32'h0, 32'h11111111);
        do_req(0, 1'b0, 32'h13, 32'd0);
        do_req(0, 1'b1, 32'h100, 32'hBAD0BAD0);
        chk("err_count_2", {24'b0, a_ecnt}, 32'd2);
        do_req(0, 1'b0, 32'h0, 32'd0);

        // req_valid held high: one accept per IDLE cycle
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) sb_q.push_back({1'b0, m_a[4]});
            chk("cont_ready", {31'b0, a_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
            chk("cont_valid", {31'b0, a_rvalid}, (i % 4 == 3) ? 32'd1 : 32'd0);
            if (a_rvalid) begin
                item = sb_q.pop_front();
                chk("cont_rdata", a_rdata, item[31:0]);
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("cont_idle", {31'b0, a_ready}, 32'd1);

        do_req(1, 1'b1, 32'h0, 32'hA5A5A5A5);
        do_req(1, 1'b1, 32'h4, 32'h5A5A5A5A);
        do_req(1, 1'b0, 32'h0, 32'd0);
        do_req(1, 1'b0, 32'h4, 32'd0);

        // abort a store with reset while it waits
        do_req(0, 1'b1, 32'h8, 32'hCAFEF00D);
        drive(0, 1'b1, 1'b1, 32'h8, 32'h12345678);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("abort_busy", {31'b0, a_busy}, 32'd1);
        reset = 1'b1;
        #1;
        ecnt_model = 0;
        chk("abort_ready", {31'b0, a_ready}, 32'd1);
        chk("abort_valid", {31'b0, a_rvalid}, 32'd0);
        chk("abort_busy0", {31'b0, a_busy}, 32'd0);
        chk("abort_rdata", a_rdata, 32'd0);
        chk("abort_err", {31'b0, a_rerr}, 32'd0);
        chk("abort_ecnt", {24'b0, a_ecnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_rvalid) seen++;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        do_req(0, 1'b0, 32'h8, 32'd0);

        for (int i = 0; i < 300; i++) begin
            do_req(0, 1'b0, 32'((i % 64) * 4 + 1 + (i % 3)), 32'd0);
        end
        chk("ecnt_sat", {24'b0, a_ecnt}, 32'd255);
        do_req(0, 1'b0, 32'h10, 32'd0);
        chk("ecnt_hold", {24'b0, a_ecnt}, 32'd255);
        chk("final_ready", {31'b0, a_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
